// File: rtl/tiny_cache_ctrl.sv
// Direct-mapped, write-through, write-allocate cache controller.
// Performs the tag/valid lookup and drives a simple rd/wr/ack memory bus.
module tiny_cache_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              cpu_flush,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              active,
    output logic              response,
    output logic [2:0]        trans,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [DATA_W-1:0] resp_data,
    output logic              memory_rd,
    output logic              memory_wr,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_wdata,
    input  logic              memory_ack,
    input  logic [DATA_W-1:0] memory_rdata
);

    localparam int LINES = 1 << INDEX_W;

    localparam logic [2:0] TR_HIT   = 3'd4;
    localparam logic [2:0] TR_MISS  = 3'd5;
    localparam logic [2:0] TR_WRITE = 3'd6;
    localparam logic [2:0] TR_RESET = 3'd7;

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, RESP} state_t;

    state_t              state_q,     state_d;
    logic                active_q,    active_d;
    logic                response_q,  response_d;
    logic [2:0]          trans_q,     trans_d;
    logic [ADDR_W-1:0]   resp_addr_q, resp_addr_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                mem_rd_q,    mem_rd_d;
    logic                mem_wr_q,    mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [LINES-1:0]    valid_q,     valid_d;

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    logic [ADDR_W-1:0]   tag_mem  [LINES];
    logic [DATA_W-1:0]   data_mem [LINES];

    logic                arr_we;
    logic [INDEX_W-1:0]  arr_idx;
    logic [ADDR_W-1:0]   arr_tag;
    logic [DATA_W-1:0]   arr_data;

    logic [INDEX_W-1:0]  idx_in;
    logic [INDEX_W-1:0]  idx_q;
    logic                hit;

    assign idx_in = cpu_addr[INDEX_W-1:0];
    assign idx_q  = addr_q[INDEX_W-1:0];
    assign hit    = valid_q[idx_in] && (tag_mem[idx_in] == cpu_addr);

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        response_d  = 1'b0;
        trans_d     = 3'd0;
        resp_addr_d = '0;
        resp_data_d = '0;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        valid_d     = valid_q;
        arr_we      = 1'b0;
        arr_idx     = idx_q;
        arr_tag     = addr_q;
        arr_data    = wdata_q;

        case (state_q)
            IDLE: begin
                active_d = 1'b0;
                if (cpu_flush || cpu_wr || cpu_rd) begin
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    active_d = 1'b1;
                end
                if (cpu_flush) begin
                    valid_d     = '0;
                    state_d     = RESP;
                    response_d  = 1'b1;
                    trans_d     = TR_RESET;
                    resp_addr_d = cpu_addr;
                end else if (cpu_wr) begin
                    // Allocate on write: the line is updated before memory sees it.
                    arr_we          = 1'b1;
                    arr_idx         = idx_in;
                    arr_tag         = cpu_addr;
                    arr_data        = cpu_wdata;
                    valid_d[idx_in] = 1'b1;
                    state_d         = MEM_WR;
                    mem_wr_d        = 1'b1;
                    mem_addr_d      = cpu_addr;
                    mem_wdata_d     = cpu_wdata;
                end else if (cpu_rd) begin
                    if (hit) begin
                        state_d     = RESP;
                        response_d  = 1'b1;
                        trans_d     = TR_HIT;
                        resp_addr_d = cpu_addr;
                        resp_data_d = data_mem[idx_in];
                    end else begin
                        state_d    = MEM_RD;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = cpu_addr;
                    end
                end
            end
            MEM_RD: begin
                if (memory_ack) begin
                    // Refill silently replaces whatever line shared this index.
                    arr_we         = 1'b1;
                    arr_data       = memory_rdata;
                    valid_d[idx_q] = 1'b1;
                    mem_rd_d       = 1'b0;
                    mem_addr_d     = '0;
                    state_d        = RESP;
                    response_d     = 1'b1;
                    trans_d        = TR_MISS;
                    resp_addr_d    = addr_q;
                    resp_data_d    = memory_rdata;
                end
            end
            MEM_WR: begin
                if (memory_ack) begin
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    state_d     = RESP;
                    response_d  = 1'b1;
                    trans_d     = TR_WRITE;
                    resp_addr_d = addr_q;
                    resp_data_d = wdata_q;
                end
            end
            RESP: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            response_q  <= 1'b0;
            trans_q     <= 3'd0;
            resp_addr_q <= '0;
            resp_data_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            response_q  <= response_d;
            trans_q     <= trans_d;
            resp_addr_q <= resp_addr_d;
            resp_data_q <= resp_data_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            valid_q     <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            tag_mem[arr_idx]  <= arr_tag;
            data_mem[arr_idx] <= arr_data;
        end
    end

    assign active         = active_q;
    assign response       = response_q;
    assign trans          = trans_q;
    assign resp_addr      = resp_addr_q;
    assign resp_data      = resp_data_q;
    assign memory_rd      = mem_rd_q;
    assign memory_wr      = mem_wr_q;
    assign memory_address = mem_addr_q;
    assign memory_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_tiny_cache_ctrl.sv
// Directed bench for tiny_cache_ctrl with a memory responder returning addr+1
// after a programmable number of wait cycles.
module tb_tiny_cache_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_flush = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0;
    logic       active, response, memory_rd, memory_wr, memory_ack;
    logic [2:0] trans;
    logic [7:0] resp_addr, resp_data, memory_address, memory_wdata, memory_rdata;

    int nchk = 0, nfail = 0;
    int wait_n = 2;
    int mcnt = 0;
    int rd_cyc = 0, wr_cyc = 0, both_cyc = 0, resp_cnt = 0;
    logic [7:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;

    always #5 clk = ~clk;

    tiny_cache_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_flush(cpu_flush),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .active(active), .response(response), .trans(trans),
        .resp_addr(resp_addr), .resp_data(resp_data),
        .memory_rd(memory_rd), .memory_wr(memory_wr),
        .memory_address(memory_address), .memory_wdata(memory_wdata),
        .memory_ack(memory_ack), .memory_rdata(memory_rdata)
    );

    // Memory responder: ack in the (wait_n+1)-th cycle of a request.
    assign memory_ack   = (memory_rd || memory_wr) && (mcnt == wait_n);
    assign memory_rdata = memory_address + 8'd1;

    always @(posedge clk) begin
        if (memory_rd || memory_wr) mcnt <= mcnt + 1;
        else                        mcnt <= 0;
    end

    always @(negedge clk) begin
        if (memory_rd) begin rd_cyc <= rd_cyc + 1; last_rd_addr <= memory_address; end
        if (memory_wr) begin
            wr_cyc <= wr_cyc + 1; last_wr_addr <= memory_address; last_wr_data <= memory_wdata;
        end
        if (memory_rd && memory_wr) both_cyc <= both_cyc + 1;
        if (response) resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic fl,
                       input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_rd = rd; cpu_wr = wr; cpu_flush = fl; cpu_addr = a; cpu_wdata = d;
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_flush = 1'b0;
    endtask

    // Waits for the response; lat counts cycles after the sampling edge.
    task automatic wait_resp(output int lat, output logic [2:0] tr,
                             output logic [7:0] ra, output logic [7:0] rdat);
        lat = 0; tr = '0; ra = '0; rdat = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (response) begin
                lat = i; tr = trans; ra = resp_addr; rdat = resp_data;
                check("active_in_resp", active, 1);
                break;
            end
        end
        if (lat == 0) check("resp_timeout", 0, 1);
    endtask

    // One full transaction with expected code, data, latency and memory cycles.
    task automatic txn(input string tag, input logic rd, input logic wr, input logic fl,
                       input logic [7:0] a, input logic [7:0] d,
                       input logic [2:0] etr, input logic [7:0] edat, input int elat,
                       input int erd, input int ewr);
        int lat, rd0, wr0;
        logic [2:0] tr;
        logic [7:0] ra, rdat;
        rd0 = rd_cyc; wr0 = wr_cyc;
        req(rd, wr, fl, a, d);
        wait_resp(lat, tr, ra, rdat);
        check({tag, "_trans"}, tr, etr);
        check({tag, "_addr"}, ra, a);
        check({tag, "_data"}, rdat, edat);
        check({tag, "_lat"}, lat, elat);
        #1;
        check({tag, "_rdcyc"}, rd_cyc - rd0, erd);
        check({tag, "_wrcyc"}, wr_cyc - wr0, ewr);
    endtask

    initial begin
        int r0;
        repeat (3) @(negedge clk);
        check("rst_active", active, 0);
        check("rst_response", response, 0);
        check("rst_trans", trans, 0);
        check("rst_memrd", memory_rd, 0);
        check("rst_memwr", memory_wr, 0);
        check("rst_memaddr", memory_address, 0);
        check("rst_respdata", resp_data, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 1: miss with two wait cycles, then hit
        wait_n = 2;
        txn("s1_miss", 1, 0, 0, 8'h23, 8'h00, 3'd5, 8'h24, 4, 3, 0);
        check("s1_rdaddr", last_rd_addr, 8'h23);
        @(negedge clk);
        check("s1_idle_active", active, 0);
        txn("s1_hit", 1, 0, 0, 8'h23, 8'h00, 3'd4, 8'h24, 1, 0, 0);

        // 2: same-index eviction
        txn("s2_a", 1, 0, 0, 8'h03, 8'h00, 3'd5, 8'h04, 4, 3, 0);
        txn("s2_b", 1, 0, 0, 8'h13, 8'h00, 3'd5, 8'h14, 4, 3, 0);
        txn("s2_c", 1, 0, 0, 8'h03, 8'h00, 3'd5, 8'h04, 4, 3, 0);

        // 3: write allocate then hit
        txn("s3_wr", 0, 1, 0, 8'h45, 8'hA5, 3'd6, 8'hA5, 4, 0, 3);
        check("s3_wraddr", last_wr_addr, 8'h45);
        check("s3_wrdata", last_wr_data, 8'hA5);
        txn("s3_hit", 1, 0, 0, 8'h45, 8'h00, 3'd4, 8'hA5, 1, 0, 0);

        // 4: flush invalidates everything
        txn("s4_flush", 0, 0, 1, 8'h00, 8'h00, 3'd7, 8'h00, 1, 0, 0);
        txn("s4_miss", 1, 0, 0, 8'h45, 8'h00, 3'd5, 8'h46, 4, 3, 0);

        // 5: write beats read, zero-wait memory, requests while busy ignored
        wait_n = 0;
        txn("s5_rdwr", 1, 1, 0, 8'h10, 8'h77, 3'd6, 8'h77, 2, 0, 1);
        check("s5_wraddr", last_wr_addr, 8'h10);
        r0 = resp_cnt;
        req(0, 1, 0, 8'h20, 8'h5A);
        @(negedge clk);
        check("s5_busy_noresp", response, 0);
        cpu_rd = 1'b1; cpu_addr = 8'h55;
        @(negedge clk);
        check("s5_resp", response, 1);
        check("s5_resp_trans", trans, 6);
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("s5_resp_count", resp_cnt - r0, 1);
        check("s5_no_rd", memory_rd, 0);
        txn("s5_rdmiss0", 1, 0, 0, 8'h33, 8'h00, 3'd5, 8'h34, 2, 1, 0);

        // 6: reset during an outstanding read
        wait_n = 6;
        r0 = resp_cnt;
        req(1, 0, 0, 8'h77, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("s6_rd_pending", memory_rd, 1);
        #1;
        reset = 1'b0;
        #1;
        check("s6_rd_drop", memory_rd, 0);
        check("s6_active_drop", active, 0);
        check("s6_addr_drop", memory_address, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("s6_no_resp", resp_cnt - r0, 0);
        wait_n = 0;
        txn("s6_after", 1, 0, 0, 8'h23, 8'h00, 3'd5, 8'h24, 2, 1, 0);

        check("never_both", both_cyc, 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
